// File: rtl/mant_addsub_pipe_pkg.sv
// Shared types for the significand datapath: opcode encoding and the result
// record passed between the add/sub unit, the normaliser and the rounder.
package mant_addsub_pipe_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mant_op_e;

  localparam int unsigned MANT_MAX_W   = 64;
  localparam int unsigned MANT_MAX_LZW = $clog2(MANT_MAX_W + 1);

  // Fields are sized for the widest legal significand; a narrower datapath
  // zero-extends into them and slices its own WIDTH/LZW bits back out.
  typedef struct packed {
    logic [MANT_MAX_W-1:0]   mag;
    logic                    sign;
    logic                    cout;
    logic                    zero;
    logic [MANT_MAX_LZW-1:0] lzc;
  } mant_res_t;

endpackage

// File: rtl/mant_addsub_pipe_lzc.sv
// Combinational leading-zero counter; all-zero input yields WIDTH.
module mant_lzc #(
  parameter  int unsigned WIDTH = 26,
  localparam int unsigned LZW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [LZW-1:0]   count_o
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    count_o = LZW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = LZW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mant_addsub_pipe.sv
// Pipelined significand add/subtract with sign-magnitude result, zero flag and
// leading-zero count; one global advance signal stalls every stage together.
module mant_addsub_pipe
  import mant_addsub_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH  = 26,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned LZW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag,
  output logic             sign,
  output logic             cout,
  output logic             zero,
  output logic [LZW-1:0]   lzc
);

  localparam int unsigned NREG = STAGES - 1;

  logic             advance;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   r_d;
  logic [WIDTH:0]   r_q [NREG];
  logic [NREG-1:0]  op_q;
  logic [NREG-1:0]  v_q;
  logic             out_valid_q;

  logic [WIDTH:0]   r_last;
  logic             op_last;
  logic [WIDTH-1:0] mag_d;
  logic             sign_d;
  logic             cout_d;
  logic [LZW-1:0]   lzc_d;
  mant_res_t        res_d;
  mant_res_t        res_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  assign b_ext = (op == SUB) ? ({1'b0, ~b} + (WIDTH + 1)'(1)) : {1'b0, b};
  assign r_d   = {1'b0, a} + b_ext;

  assign r_last  = r_q[NREG-1];
  assign op_last = op_q[NREG-1];

  // A subtract borrows (bit WIDTH clear) only when B > A, so the negated
  // magnitude is never zero and A == B cannot produce a negative zero.
  always_comb begin
    mag_d  = r_last[WIDTH-1:0];
    sign_d = 1'b0;
    cout_d = 1'b0;
    if (op_last == SUB) begin
      if (!r_last[WIDTH]) begin
        mag_d  = -r_last[WIDTH-1:0];
        sign_d = 1'b1;
      end
    end else begin
      cout_d = r_last[WIDTH];
    end
  end

  mant_lzc #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .data_i  (mag_d),
    .count_o (lzc_d)
  );

  always_comb begin
    res_d      = '0;
    res_d.mag  = MANT_MAX_W'(mag_d);
    res_d.sign = sign_d;
    res_d.cout = cout_d;
    res_d.zero = (mag_d == '0);
    res_d.lzc  = MANT_MAX_LZW'(lzc_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_q[i] <= '0;
      end
      op_q        <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (advance) begin
      r_q[0]  <= r_d;
      op_q[0] <= op;
      v_q[0]  <= in_valid;
      for (int unsigned i = 1; i < NREG; i++) begin
        r_q[i]  <= r_q[i-1];
        op_q[i] <= op_q[i-1];
        v_q[i]  <= v_q[i-1];
      end
      out_valid_q <= v_q[NREG-1];
      // Result data only moves on a valid slot so outputs stay 0 until the first result.
      if (v_q[NREG-1]) begin
        res_q <= res_d;
      end
    end
  end

  logic unused_res_hi;
  assign unused_res_hi = ^{res_q.mag, res_q.lzc};

  assign out_valid = out_valid_q;
  assign mag       = res_q.mag[WIDTH-1:0];
  assign sign      = res_q.sign;
  assign cout      = res_q.cout;
  assign zero      = res_q.zero;
  assign lzc       = res_q.lzc[LZW-1:0];

endmodule

// File: tb/tb_mant_addsub_pipe.sv
// Self-checking bench: behavioural scoreboard plus directed literal cases,
// for a STAGES=2 unit under random backpressure and a STAGES=4 unit.
module tb_mant_addsub_pipe;

  localparam int W   = 26;
  localparam int LZW = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0, in_valid4 = 1'b0;
  logic           in_ready, in_ready4;
  logic           op = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           out_valid, out_valid4;
  logic           out_ready = 1'b1, out_ready4 = 1'b1;
  logic [W-1:0]   mag, mag4;
  logic           sign, sign4, cout, cout4, zero, zero4;
  logic [LZW-1:0] lzc, lzc4;

  mant_addsub_pipe #(.WIDTH(W), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .sign(sign), .cout(cout), .zero(zero), .lzc(lzc)
  );

  mant_addsub_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready4),
    .mag(mag4), .sign(sign4), .cout(cout4), .zero(zero4), .lzc(lzc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mag;
    bit           sign;
    bit           cout;
    bit           zero;
    int           lzc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t sb4[$];
  int   out_cyc[$];
  int   out4_cyc[$];
  int   n_acc = 0, n_out = 0;

  function automatic exp_t model(bit o, longint unsigned x, longint unsigned y);
    exp_t e;
    longint unsigned s, v;
    int k;
    e.sign = 1'b0;
    e.cout = 1'b0;
    if (!o) begin
      s      = x + y;
      e.mag  = W'(s);
      e.cout = (s >> W) != 0;
    end else if (x >= y) begin
      e.mag = W'(x - y);
    end else begin
      e.mag  = W'(y - x);
      e.sign = 1'b1;
    end
    e.zero = (e.mag == 0);
    v = longint'(e.mag);
    k = 0;
    while (v != 0) begin
      v = v >> 1;
      k++;
    end
    e.lzc = W - k;
    return e;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [W-1:0] m,
                         input logic s, input logic c, input logic z, input logic [LZW-1:0] l);
    chk({tag, ".mag"}, longint'(m), longint'(e.mag));
    chk({tag, ".sign"}, longint'(s), longint'(e.sign));
    chk({tag, ".cout"}, longint'(c), longint'(e.cout));
    chk({tag, ".zero"}, longint'(z), longint'(e.zero));
    chk({tag, ".lzc"}, longint'(l), longint'(e.lzc));
  endtask

  // Compare process: transfers are judged at the falling edge before the edge that performs them.
  bit             prev_stall = 1'b0;
  logic [W-1:0]   s_mag;
  logic           s_sign, s_cout, s_zero;
  logic [LZW-1:0] s_lzc;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_mag", longint'(mag), longint'(s_mag));
        chk("stall_flags", longint'({sign, cout, zero}), longint'({s_sign, s_cout, s_zero}));
        chk("stall_lzc", longint'(lzc), longint'(s_lzc));
      end
      chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b));
        n_acc++;
      end
      if (in_valid4 && in_ready4) sb4.push_back(model(op, a, b));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got result mag=%0d expected none", mag);
        end else begin
          cmp_res("s2", sb.pop_front(), mag, sign, cout, zero, lzc);
        end
        out_cyc.push_back(cyc);
        n_out++;
      end
      if (out_valid4 && out_ready4) begin
        checks++;
        if (sb4.size() == 0) begin
          errors++;
          $display("FAIL spurious_out4: got result mag=%0d expected none", mag4);
        end else begin
          cmp_res("s4", sb4.pop_front(), mag4, sign4, cout4, zero4, lzc4);
        end
        out4_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      s_mag = mag; s_sign = sign; s_cout = cout; s_zero = zero; s_lzc = lzc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    int n;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input longint em, input bit es, input bit ec, input bit ez, input int el);
    int edges;
    out_ready = 1'b1;
    send(o, x, y);
    edges = 1;
    while (!out_valid && edges < 50) begin
      step();
      edges++;
    end
    chk({tag, ".latency"}, edges, 2);
    chk({tag, ".mag"}, longint'(mag), em);
    chk({tag, ".sign"}, longint'(sign), longint'(es));
    chk({tag, ".cout"}, longint'(cout), longint'(ec));
    chk({tag, ".zero"}, longint'(zero), longint'(ez));
    chk({tag, ".lzc"}, longint'(lzc), el);
    step();
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size() + sb4.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  bit done = 1'b0;

  initial begin
    logic [W-1:0] x, y;
    bit o;
    int m, edges, first4, seen;

    #12;
    chk("rst.out_valid", longint'(out_valid), 0);
    chk("rst.mag", longint'(mag), 0);
    chk("rst.zero", longint'(zero), 0);
    chk("rst.lzc", longint'(lzc), 0);
    chk("rst.out_valid4", longint'(out_valid4), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", longint'(in_ready), 1);

    directed("sub_ab", 1'b1, W'(415), W'(215), 200, 1'b0, 1'b0, 1'b0, 18);
    directed("add_ab", 1'b0, W'(415), W'(215), 630, 1'b0, 1'b0, 1'b0, 16);
    directed("sub_ba", 1'b1, W'(215), W'(415), 200, 1'b1, 1'b0, 1'b0, 18);
    directed("add_max", 1'b0, W'(26'h3FFFFFF), W'(26'h3FFFFFF), 64'h3FFFFFE, 1'b0, 1'b1, 1'b0, 0);
    directed("sub_eq", 1'b1, W'(16'h1234), W'(16'h1234), 0, 1'b0, 1'b0, 1'b1, 26);

    // Back-to-back stream of 8 on the two-stage unit.
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), rnd(), rnd());
    drain();
    chk("b2b.count", out_cyc.size(), 8);
    if (out_cyc.size() == 8) chk("b2b.span", out_cyc[7] - out_cyc[0], 7);

    // Back-to-back stream of 8 on the four-stage unit.
    out4_cyc.delete();
    first4 = 0;
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid4 = 1'b1; op = 1'($urandom_range(0, 1)); a = rnd(); b = rnd();
      step();
      edges++;
      if (out_valid4 && first4 == 0) first4 = edges;
    end
    in_valid4 = 1'b0;
    while (first4 == 0 && edges < 50) begin
      step();
      edges++;
      if (out_valid4) first4 = edges;
    end
    chk("s4.latency", first4, 4);
    drain();
    chk("s4.count", out4_cyc.size(), 8);
    if (out4_cyc.size() == 8) chk("s4.span", out4_cyc[7] - out4_cyc[0], 7);

    // Random operands under 50% backpressure.
    n_acc = 0; n_out = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          m = $urandom_range(0, 7);
          o = 1'($urandom_range(0, 1));
          x = rnd(); y = rnd();
          if (m == 0) y = x;
          if (m == 1) x = '1;
          if (m == 2) y = '1;
          if (m == 3) x = '0;
          send(o, x, y);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain();
    chk("rand.accepted", n_acc, 200);
    chk("rand.emitted", n_out, 200);

    // Reset while two operations are in flight.
    send(1'b0, W'(1000), W'(24));
    send(1'b1, W'(5), W'(9));
    rst_n = 1'b0;
    sb.delete();
    sb4.delete();
    #1;
    chk("flush.out_valid", longint'(out_valid), 0);
    chk("flush.mag", longint'(mag), 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush.no_stale", seen, 0);
    directed("post_flush", 1'b1, W'(100), W'(1), 99, 1'b0, 1'b0, 1'b0, 19);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mant_addsub_pipe.md
Name: mant_addsub_pipe

Overview:
- Pipelined, parametrised significand add/subtract unit for the IEEE-754 datapath. Sits between exponent alignment and normalisation.
- Returns sign-magnitude results: |A-B| plus sign on subtract; carry-out on add. Also returns a zero flag and a leading-zero count, so the normaliser needs no second pass.
- Valid/ready handshakes on both sides; full throughput of one operation per cycle; supports backpressure.

Parameters:
- WIDTH, 26, significand width in bits, including guard bits; legal range 8..64.
- STAGES, 2, input-to-output latency in cycles; legal values 2, 3, 4.
- LZW, $clog2(WIDTH+1), width of the leading-zero-count output (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  unit can accept this cycle.
- op  in  1  0 = add, 1 = subtract.
- a  in  WIDTH  unsigned operand A.
- b  in  WIDTH  unsigned operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- mag  out  WIDTH  result magnitude.
- sign  out  1  1 when a subtract had B>A; always 0 for add.
- cout  out  1  add carry-out; always 0 for subtract.
- zero  out  1  mag == 0.
- lzc  out  LZW  leading zeros of mag; equals WIDTH when mag == 0.

Behaviour:
- Reset: every stage valid bit, out_valid and all data outputs go to 0 asynchronously. in_ready is 1 one cycle after release.
- Stall rule: advance = !out_valid || out_ready. in_ready = advance (combinational). When advance = 0, every pipeline register holds and the outputs stay stable.
- Transfer: an input is accepted on a rising edge with in_valid && in_ready. An output is consumed on a rising edge with out_valid && out_ready.
- Latency: an accepted operation appears on the outputs exactly STAGES edges later, absent stalls. A stall of N cycles adds N cycles.
- Pipeline bubbles: an invalid slot does not block the stages behind it. Bubbles collapse only through the global advance signal; no per-stage compaction is required.
- Stage 1 registers r = a + (op ? ~b + 1 : b), computed at WIDTH+1 bits, together with op and valid.
- Stages 2..STAGES-1 are pure delay registers.
- Final stage computes and registers:
  - op=0: mag = r[WIDTH-1:0], cout = r[WIDTH], sign = 0.
  - op=1, r[WIDTH]=1 (A>=B): mag = r[WIDTH-1:0], sign = 0.
  - op=1, r[WIDTH]=0 (A<B): mag = -r[WIDTH-1:0] (two's complement), sign = 1.
  - cout = 0 for every subtract.
- zero is asserted when mag == 0. A subtract with A == B gives sign = 0, never a negative zero.
- lzc counts from mag[WIDTH-1] downward. On add overflow (cout = 1), lzc is still computed on mag; the consumer checks cout first.
- Simultaneous output consume and input accept in the same cycle is legal and sustains 1 op/cycle.
- No operation is dropped or duplicated under any in_valid/out_ready pattern.
- Reset asserted mid-stream flushes all in-flight operations; none are emitted after reset releases.
- Data registers of invalid slots are don't-care internally, but the outputs are 0 until the first valid result.

Decomposition:
- Shared package: opcode constants ADD = 1'b0, SUB = 1'b1; a result-struct typedef {mag, sign, cout, zero, lzc} parametrised by WIDTH, so the normaliser and the rounder can reuse it.
- One sub-module, mant_lzc: parametrised combinational leading-zero counter (WIDTH in, LZW out, returns WIDTH for all-zero input). The adder is inline; the team CLA may replace it without changing the interface.

Test Plan:
- WIDTH=26, STAGES=2; a=415, b=215, op=1 -> after 2 edges: mag=200, sign=0, cout=0, zero=0, lzc=18.
- a=415, b=215, op=0 -> mag=630, cout=0, lzc=16. Swap to a=215, b=415, op=1 -> mag=200, sign=1.
- a=b=0x3FFFFFF, op=0 -> mag=0x3FFFFFE, cout=1, lzc=0. Then a=b=0x1234, op=1 -> mag=0, zero=1, sign=0, lzc=26.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 results on consecutive cycles in order. Repeat with STAGES=4 -> first result 4 edges after the first accept.
- Random out_ready toggling (50%) over 200 ops -> outputs stable while stalled, in_ready=0 whenever out_valid && !out_ready, result sequence matches the reference model with no drop or duplicate.
- Drop rst_n for 1 cycle while 2 ops are in flight -> out_valid=0 immediately; no stale result appears after release; the next accepted op emerges after STAGES edges.
